// File: rtl/mem_map_pkg.sv
// Shared memory-map definitions for the address port: region and FSM encodings,
// default region boundaries and the wait-state counter width.
package mem_map_pkg;

  localparam logic [15:0] ROM_TOP_DEF = 16'h7FFF;
  localparam logic [15:0] IO_BASE_DEF = 16'hFF00;
  localparam int unsigned WS_W        = 3;

  typedef enum logic [1:0] {
    REG_ROM,
    REG_RAM,
    REG_IO
  } region_e;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } port_state_e;

endpackage

// File: rtl/addr_region_decode.sv
// Combinational address decoder: maps a 16-bit address to its memory region and the
// number of extra wait cycles that region needs. Also used by the bus monitor.
module addr_region_decode
  import mem_map_pkg::*;
#(
  parameter logic [15:0] ROM_TOP = ROM_TOP_DEF,
  parameter logic [15:0] IO_BASE = IO_BASE_DEF,
  parameter int unsigned ROM_WS  = 1,
  parameter int unsigned RAM_WS  = 0,
  parameter int unsigned IO_WS   = 2
) (
  input  logic [15:0]     addr,
  output region_e         region,
  output logic [WS_W-1:0] ws
);

  always_comb begin
    region = REG_RAM;
    ws     = WS_W'(RAM_WS);
    if (addr <= ROM_TOP) begin
      region = REG_ROM;
      ws     = WS_W'(ROM_WS);
    end else if (addr >= IO_BASE) begin
      region = REG_IO;
      ws     = WS_W'(IO_WS);
    end
  end

endmodule

// File: rtl/memory_address_port.sv
// Address register plus access sequencer: decodes ROM/RAM/IO, runs wait states, drives
// chip selects and strobes. Define MAR_AUTOINC_EN to post-increment the address per access.
module memory_address_port
  import mem_map_pkg::*;
#(
  parameter logic [15:0] ROM_TOP = ROM_TOP_DEF,
  parameter logic [15:0] IO_BASE = IO_BASE_DEF,
  parameter int unsigned ROM_WS  = 1,
  parameter int unsigned RAM_WS  = 0,
  parameter int unsigned IO_WS   = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        loadn,
  input  logic        rdn,
  input  logic        wrn,
  input  logic [15:0] abus,
  output logic [15:0] mem_addr,
  output logic        rom_csn,
  output logic        ram_csn,
  output logic        io_csn,
  output logic        oen,
  output logic        wen,
  output logic        busy,
  output logic        rdy
);

  port_state_e     state_q, state_d;
  region_e         region_q, region_d;
  logic            write_q, write_d;
  logic [WS_W-1:0] cnt_q, cnt_d;
  logic            rdy_q, rdy_d;
  logic [15:0]     addr_q, addr_d;

  logic [15:0]     addr_eff;
  region_e         dec_region;
  logic [WS_W-1:0] dec_ws;
  logic            req_rd, req_wr;

  // A request on the same edge as a load must be decoded against the incoming address.
  assign addr_eff = (!loadn) ? abus : addr_q;
  assign req_rd   = !rdn && wrn;
  assign req_wr   = rdn && !wrn;

  addr_region_decode #(
    .ROM_TOP (ROM_TOP),
    .IO_BASE (IO_BASE),
    .ROM_WS  (ROM_WS),
    .RAM_WS  (RAM_WS),
    .IO_WS   (IO_WS)
  ) u_decode (
    .addr   (addr_eff),
    .region (dec_region),
    .ws     (dec_ws)
  );

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    write_d  = write_q;
    cnt_d    = cnt_q;
    rdy_d    = 1'b0;
    addr_d   = addr_q;
    unique case (state_q)
      StIdle: begin
        if (!loadn) addr_d = abus;
        if (req_rd || req_wr) begin
          state_d  = StAccess;
          region_d = dec_region;
          write_d  = req_wr;
          // ROM writes are swallowed, so they need no wait states.
          cnt_d    = (req_wr && dec_region == REG_ROM) ? '0 : dec_ws;
        end
      end
      StAccess: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = StDone;
          rdy_d   = 1'b1;
`ifdef MAR_AUTOINC_EN
          addr_d  = addr_q + 16'd1;
`endif
        end
      end
      StDone: begin
        if (rdn && wrn) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      region_q <= REG_ROM;
      write_q  <= 1'b0;
      cnt_q    <= '0;
      rdy_q    <= 1'b0;
      addr_q   <= 16'h0000;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      write_q  <= write_d;
      cnt_q    <= cnt_d;
      rdy_q    <= rdy_d;
      addr_q   <= addr_d;
    end
  end

  logic in_access;
  assign in_access = (state_q == StAccess);

  always_comb begin
    rom_csn = !(in_access && region_q == REG_ROM && !write_q);
    ram_csn = !(in_access && region_q == REG_RAM);
    io_csn  = !(in_access && region_q == REG_IO);
    oen     = !(in_access && !write_q);
    wen     = !(in_access && write_q && region_q != REG_ROM);
  end

  assign busy     = (state_q != StIdle);
  assign rdy      = rdy_q;
  assign mem_addr = addr_q;

endmodule

// File: tb/tb_memory_address_port.sv
// Directed self-checking bench for memory_address_port (default ROM_WS=1, RAM_WS=0, IO_WS=2).
module tb_memory_address_port;

  logic        clk = 1'b0;
  logic        resetn, loadn, rdn, wrn;
  logic [15:0] abus;
  logic [15:0] mem_addr;
  logic        rom_csn, ram_csn, io_csn, oen, wen, busy, rdy;

  int tests = 0;
  int fails = 0;

  // Output vector order: {rom_csn, ram_csn, io_csn, oen, wen, busy, rdy}
  localparam logic [6:0] V_IDLE = 7'b1111100;
  localparam logic [6:0] V_DONE = 7'b1111111;
  localparam logic [6:0] V_HOLD = 7'b1111110;

  memory_address_port dut (
    .clk      (clk),
    .resetn   (resetn),
    .loadn    (loadn),
    .rdn      (rdn),
    .wrn      (wrn),
    .abus     (abus),
    .mem_addr (mem_addr),
    .rom_csn  (rom_csn),
    .ram_csn  (ram_csn),
    .io_csn   (io_csn),
    .oen      (oen),
    .wen      (wen),
    .busy     (busy),
    .rdy      (rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {rom_csn, ram_csn, io_csn, oen, wen, busy, rdy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; loadn = 1'b1; rdn = 1'b1; wrn = 1'b1; abus = 16'h0000;
    #3;
    tests++;
    if (outs() !== V_IDLE) begin
      fails++; $display("FAIL reset_outs got %b want %b", outs(), V_IDLE);
    end
    tests++;
    if (mem_addr !== 16'h0000) begin
      fails++; $display("FAIL reset_addr got %h want 0000", mem_addr);
    end
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_ram_read();
    logic [15:0] exp_addr;
    loadn = 1'b0; abus = 16'h8123;
    tick();
    loadn = 1'b1; rdn = 1'b0;
    tick();
    tests++;
    if (outs() !== 7'b1010110) begin
      fails++; $display("FAIL ram_read_strobe got %b want 1010110", outs());
    end
    tick();
    tests++;
    if (outs() !== V_DONE) begin
      fails++; $display("FAIL ram_read_rdy got %b want %b", outs(), V_DONE);
    end
    tick();
    tests++;
    if (outs() !== V_HOLD) begin
      fails++; $display("FAIL ram_read_hold got %b want %b", outs(), V_HOLD);
    end
    rdn = 1'b1;
    tick();
    tests++;
    if (outs() !== V_IDLE) begin
      fails++; $display("FAIL ram_read_release got %b want %b", outs(), V_IDLE);
    end
`ifdef MAR_AUTOINC_EN
    exp_addr = 16'h8124;
`else
    exp_addr = 16'h8123;
`endif
    tests++;
    if (mem_addr !== exp_addr) begin
      fails++; $display("FAIL ram_read_addr got %h want %h", mem_addr, exp_addr);
    end
  endtask

  task automatic test_rom_write();
    // Load and write request on the same edge: decoded as ROM.
    loadn = 1'b0; abus = 16'h0010; wrn = 1'b0;
    tick();
    loadn = 1'b1;
    tests++;
    if (outs() !== V_HOLD) begin
      fails++; $display("FAIL rom_write_nostrobe got %b want %b", outs(), V_HOLD);
    end
    tick();
    tests++;
    if (outs() !== V_DONE) begin
      fails++; $display("FAIL rom_write_rdy got %b want %b", outs(), V_DONE);
    end
    wrn = 1'b1;
    tick();
    tests++;
    if (outs() !== V_IDLE) begin
      fails++; $display("FAIL rom_write_release got %b want %b", outs(), V_IDLE);
    end
  endtask

  task automatic test_rom_read();
    loadn = 1'b0; abus = 16'h0100;
    tick();
    loadn = 1'b1; rdn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if (outs() !== 7'b0110110) begin
        fails++; $display("FAIL rom_read_strobe[%0d] got %b want 0110110", i, outs());
      end
    end
    tick();
    tests++;
    if (outs() !== V_DONE) begin
      fails++; $display("FAIL rom_read_rdy got %b want %b", outs(), V_DONE);
    end
    rdn = 1'b1;
    tick();
  endtask

  task automatic test_ram_write();
    loadn = 1'b0; abus = 16'h9000;
    tick();
    loadn = 1'b1; wrn = 1'b0;
    tick();
    tests++;
    if (outs() !== 7'b1011010) begin
      fails++; $display("FAIL ram_write_strobe got %b want 1011010", outs());
    end
    tick();
    tests++;
    if (outs() !== V_DONE) begin
      fails++; $display("FAIL ram_write_rdy got %b want %b", outs(), V_DONE);
    end
    wrn = 1'b1;
    tick();
  endtask

  task automatic test_io_read_load_ignored();
    logic [15:0] exp_addr;
    loadn = 1'b0; abus = 16'hFF05;
    tick();
    loadn = 1'b1; rdn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      loadn = 1'b0; abus = 16'h1234;
      tests++;
      if (outs() !== 7'b1100110) begin
        fails++; $display("FAIL io_read_strobe[%0d] got %b want 1100110", i, outs());
      end
    end
    tick();
    tests++;
    if (outs() !== V_DONE) begin
      fails++; $display("FAIL io_read_rdy got %b want %b", outs(), V_DONE);
    end
`ifdef MAR_AUTOINC_EN
    exp_addr = 16'hFF06;
`else
    exp_addr = 16'hFF05;
`endif
    tests++;
    if (mem_addr !== exp_addr) begin
      fails++; $display("FAIL load_during_access got %h want %h", mem_addr, exp_addr);
    end
    loadn = 1'b1; rdn = 1'b1;
    tick();
  endtask

  task automatic test_both_low();
    rdn = 1'b0; wrn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if (outs() !== V_IDLE) begin
        fails++; $display("FAIL both_low[%0d] got %b want %b", i, outs(), V_IDLE);
      end
    end
    rdn = 1'b1; wrn = 1'b1;
    tick();
  endtask

  task automatic test_hold_rdn();
    int rdy_seen, strobe_seen, idle_seen;
    rdy_seen = 0; strobe_seen = 0; idle_seen = 0;
    loadn = 1'b0; abus = 16'h8000;
    tick();
    loadn = 1'b1; rdn = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rdy === 1'b1) rdy_seen++;
      if (ram_csn !== 1'b1 || oen !== 1'b1) strobe_seen++;
      if (busy !== 1'b1) idle_seen++;
    end
    tests++;
    if (rdy_seen != 1) begin
      fails++; $display("FAIL hold_rdn_rdy_count got %0d want 1", rdy_seen);
    end
    tests++;
    if (strobe_seen != 0 || idle_seen != 0) begin
      fails++; $display("FAIL hold_rdn_second_access strobes %0d idle %0d want 0 0",
                        strobe_seen, idle_seen);
    end
    rdn = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    int rdy_seen;
    rdy_seen = 0;
    loadn = 1'b0; abus = 16'hFF10;
    tick();
    loadn = 1'b1; rdn = 1'b0;
    tick();
    resetn = 1'b0;
    #1;
    tests++;
    if (outs() !== V_IDLE) begin
      fails++; $display("FAIL reset_mid_outs got %b want %b", outs(), V_IDLE);
    end
    tests++;
    if (mem_addr !== 16'h0000) begin
      fails++; $display("FAIL reset_mid_addr got %h want 0000", mem_addr);
    end
    rdn = 1'b1;
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rdy === 1'b1) rdy_seen++;
    end
    tests++;
    if (rdy_seen != 0) begin
      fails++; $display("FAIL reset_mid_rdy got %0d pulses want 0", rdy_seen);
    end
  endtask

  task automatic test_autoinc_wrap();
    logic [15:0] exp_addr;
    loadn = 1'b0; abus = 16'hFFFF;
    tick();
    loadn = 1'b1; rdn = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rdn = 1'b1;
    tick();
`ifdef MAR_AUTOINC_EN
    exp_addr = 16'h0000;
`else
    exp_addr = 16'hFFFF;
`endif
    tests++;
    if (mem_addr !== exp_addr) begin
      fails++; $display("FAIL autoinc_wrap got %h want %h", mem_addr, exp_addr);
    end
  endtask

  initial begin
    test_reset();
    test_ram_read();
    test_rom_write();
    test_rom_read();
    test_ram_write();
    test_io_read_load_ignored();
    test_both_low();
    test_hold_rdn();
    test_reset_mid();
    test_autoinc_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
